// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_pkg
// Brief    : Shared types and defaults for the round-robin FIFO drain stage.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

    localparam int c_def_num_ch     = 4;
    localparam int c_def_data_width = 16;
    localparam int c_def_ch_bits    = 2;
    localparam int c_def_max_burst  = 4;

    typedef enum logic [1:0] {
        ARB = 2'd0,
        POP = 2'd1,
        CAP = 2'd2,
        OUT = 2'd3
    } drain_state_t;

    // Counter must be able to hold MAX_BURST itself, hence the +1.
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first request after last_grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_drain_pkg::*;
#(
    parameter int NUM_CH  = c_def_num_ch,
    parameter int CH_BITS = c_def_ch_bits
) (
    input  logic [NUM_CH-1:0]  i_req,
    input  logic [CH_BITS-1:0] i_last_grant,
    output logic [CH_BITS-1:0] o_grant,
    output logic               o_any_req
);

    logic [CH_BITS-1:0] w_hi;
    logic [CH_BITS-1:0] w_lo;
    logic               w_hi_found;

    // Descending scan leaves the lowest matching index in each candidate:
    // w_hi is the first request above last_grant, w_lo is the wrap fallback.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo = CH_BITS'(i);
                if (i > int'(i_last_grant)) begin
                    w_hi       = CH_BITS'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign o_grant   = w_hi_found ? w_hi : w_lo;
    assign o_any_req = |i_req;

endmodule
`default_nettype wire

// File: rtl/fifo_rr_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_drain
// Brief    : Round-robin drain of NUM_CH registered-read FIFOs onto valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_drain
    import fifo_drain_pkg::*;
#(
    parameter int NUM_CH     = c_def_num_ch,
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int CH_BITS    = c_def_ch_bits,
    parameter int MAX_BURST  = c_def_max_burst
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            i_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_pop,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [CH_BITS-1:0]           o_ch
);

    localparam int c_burst_w = burst_cnt_width(MAX_BURST);

    drain_state_t          r_state;
    drain_state_t          w_state_nxt;
    logic [CH_BITS-1:0]    r_grant;
    logic [CH_BITS-1:0]    r_last_grant;
    logic [c_burst_w-1:0]  r_burst_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CH_BITS-1:0]    r_ch;
    logic                  r_valid;

    logic [CH_BITS-1:0]    w_pick;
    logic                  w_any_req;
    logic                  w_handshake;
    logic                  w_continue;
    logic [DATA_WIDTH-1:0] w_ch_data [NUM_CH];
    logic [DATA_WIDTH-1:0] w_sel_data;

    rr_pick #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_rr_pick (
        .i_req        (~i_empty),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick),
        .o_any_req    (w_any_req)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_ch_data[g] = i_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pop strobe is purely state-decoded and gated by reset so that no FIFO
    // sees a pop while the shared reset is asserted.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pop
        assign o_pop[g] = rst_n && (r_state == POP) && (r_grant == CH_BITS'(g));
    end

    assign w_sel_data  = w_ch_data[r_grant];
    assign w_handshake = (r_state == OUT) && r_valid && i_ready;
    // Uses the pre-increment count; the empty flag already reflects the last pop.
    assign w_continue  = ((int'(r_burst_cnt) + 1) < MAX_BURST) && !i_empty[r_grant];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB: begin
                if (w_any_req) begin
                    w_state_nxt = POP;
                end
            end
            POP: w_state_nxt = CAP;
            CAP: w_state_nxt = OUT;
            OUT: begin
                if (w_handshake) begin
                    w_state_nxt = w_continue ? POP : ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_last_grant <= CH_BITS'(NUM_CH - 1);
            r_burst_cnt  <= '0;
            r_data       <= '0;
            r_ch         <= '0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                ARB: begin
                    r_burst_cnt <= '0;
                    if (w_any_req) begin
                        r_grant <= w_pick;
                    end
                end
                CAP: begin
                    r_data  <= w_sel_data;
                    r_ch    <= r_grant;
                    r_valid <= 1'b1;
                end
                OUT: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (r_burst_cnt != c_burst_w'(MAX_BURST)) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                        if (!w_continue) begin
                            r_last_grant <= r_grant;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ch    = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_drain
// Brief    : Directed bench for fifo_rr_drain with behavioural upstream FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_rr_drain;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int CHB    = 2;
    localparam int MAXB   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    empty;
    logic [NUM_CH*DW-1:0] data;
    logic [NUM_CH-1:0]    pop;
    logic                 valid;
    logic                 ready;
    logic [DW-1:0]        odata;
    logic [CHB-1:0]       och;

    always #5 clk = ~clk;

    fifo_rr_drain #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .CH_BITS    (CHB),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_empty (empty),
        .i_data  (data),
        .o_pop   (pop),
        .o_valid (valid),
        .i_ready (ready),
        .o_data  (odata),
        .o_ch    (och)
    );

    // Upstream FIFO model: contents plus a registered read port.
    logic [DW-1:0]  q    [NUM_CH][$];
    logic [DW-1:0]  dout [NUM_CH];
    logic [CHB-1:0] log_ch[$];
    logic [DW-1:0]  log_data[$];
    int             log_cyc[$];
    int             pop_cyc[$];
    int             pop_chn[$];
    int             total   = 0;
    int             bad     = 0;
    int             cyc     = 0;
    int             pop_err = 0;

    task automatic refresh();
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i]           = (q[i].size() == 0);
            data[i*DW +: DW]   = dout[i];
        end
    endtask

    task automatic push(input int ch, input logic [DW-1:0] w);
        q[ch].push_back(w);
        refresh();
    endtask

    task automatic clear_logs();
        log_ch.delete();
        log_data.delete();
        log_cyc.delete();
        pop_cyc.delete();
        pop_chn.delete();
    endtask

    // Called at a falling edge: sample, cross one rising edge, update FIFOs.
    task automatic step();
        logic [NUM_CH-1:0] p;
        p = pop;
        for (int i = 0; i < NUM_CH; i++) begin
            if (p[i] && empty[i]) pop_err++;
            if (p[i]) begin
                pop_cyc.push_back(cyc);
                pop_chn.push_back(i);
            end
        end
        if (valid && ready) begin
            log_ch.push_back(och);
            log_data.push_back(odata);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                q[i].delete();
                dout[i] = '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (p[i] && q[i].size() > 0) dout[i] = q[i].pop_front();
            end
        end
        refresh();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (log_ch.size() < n && k < budget) begin
            step();
            k++;
        end
        total++;
        if (log_ch.size() < n) begin
            bad++;
            $display("FAIL %s timeout: outputs=%0d required=%0d", name, log_ch.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(1);
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        run(2);
        total++;
        if ({valid, och, odata, pop} !== {1'b0, 2'd0, 16'h0000, 4'b0000}) begin
            bad++;
            $display("FAIL reset_state: valid=%b ch=%0d data=%h pop=%b required 0/0/0000/0000",
                     valid, och, odata, pop);
        end
        rst_n = 1'b1;
        run(3);
        total++;
        if (valid !== 1'b0 || pop !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_reset: valid=%b pop=%b required 0/0000", valid, pop);
        end
        clear_logs();
    endtask

    task automatic test_single_channel();
        int t0;
        ready = 1'b1;
        push(2, 16'hA001);
        push(2, 16'hA002);
        push(2, 16'hA003);
        t0 = cyc;
        run(20);
        total++;
        if (log_ch.size() != 3 || pop_cyc.size() != 3) begin
            bad++;
            $display("FAIL single_counts: outputs=%0d pops=%0d required 3/3", log_ch.size(), pop_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (log_ch[i] !== 2'd2 || log_data[i] !== 16'hA001 + 16'(i) || pop_chn[i] != 2) begin
                    bad++;
                    $display("FAIL single_word%0d: ch=%0d data=%h popch=%0d required 2/%h/2",
                             i, log_ch[i], log_data[i], pop_chn[i], 16'hA001 + 16'(i));
                end
            end
            total++;
            if (pop_cyc[0] != t0 + 1 || log_cyc[0] != t0 + 3) begin
                bad++;
                $display("FAIL single_latency: pop@%0d valid@%0d required %0d/%0d",
                         pop_cyc[0] - t0, log_cyc[0] - t0, 1, 3);
            end
            total++;
            if (pop_cyc[1] - pop_cyc[0] != 3 || pop_cyc[2] - pop_cyc[1] != 3) begin
                bad++;
                $display("FAIL single_spacing: gaps=%0d,%0d required 3,3",
                         pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
            end
        end
        total++;
        if (valid !== 1'b0 || pop !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle: valid=%b pop=%b required 0/0000", valid, pop);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            for (int c = 0; c < NUM_CH; c++) push(c, 16'hB000 + 16'(pass * 256 + c));
            run_until(4, 60, "rr");
            if (log_ch.size() >= 4) begin
                for (int i = 0; i < 4; i++) begin
                    total++;
                    if (log_ch[i] !== CHB'(i) || log_data[i] !== 16'hB000 + 16'(pass * 256 + i)) begin
                        bad++;
                        $display("FAIL rr_pass%0d_slot%0d: ch=%0d data=%h required %0d/%h",
                                 pass, i, log_ch[i], log_data[i], i, 16'hB000 + 16'(pass * 256 + i));
                    end
                end
            end
        end
    endtask

    task automatic test_burst_limit();
        logic [CHB-1:0] exp_ch [8];
        logic [DW-1:0]  exp_d  [8];
        exp_ch = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        exp_d  = '{16'hD000, 16'hD001, 16'hD002, 16'hD003,
                   16'hD100, 16'hD101, 16'hD004, 16'hD005};
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 6; k++) push(0, 16'hD000 + 16'(k));
        for (int k = 0; k < 2; k++) push(1, 16'hD100 + 16'(k));
        run_until(8, 80, "burst");
        if (log_ch.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (log_ch[i] !== exp_ch[i] || log_data[i] !== exp_d[i]) begin
                    bad++;
                    $display("FAIL burst_slot%0d: ch=%0d data=%h required %0d/%h",
                             i, log_ch[i], log_data[i], exp_ch[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        ready = 1'b0;
        push(1, 16'h5555);
        push(1, 16'h5556);
        k = 0;
        while (!valid && k < 10) begin
            step();
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({valid, och, odata, pop} !== {1'b1, 2'd1, 16'h5555, 4'b0000}) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b ch=%0d data=%h pop=%b required 1/1/5555/0000",
                         i, valid, och, odata, pop);
            end
            step();
        end
        ready = 1'b1;
        step();
        total++;
        if (log_ch.size() != 1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: handshakes=%0d valid=%b required 1/0", log_ch.size(), valid);
        end
        run_until(2, 20, "bp_drain");
        if (log_ch.size() >= 2) begin
            total++;
            if (log_data[0] !== 16'h5555 || log_data[1] !== 16'h5556) begin
                bad++;
                $display("FAIL bp_order: data=%h,%h required 5555,5556", log_data[0], log_data[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        ready = 1'b1;
        push(3, 16'hE300);
        push(3, 16'hE301);
        k = 0;
        while (pop === 4'b0000 && k < 10) begin
            step();
            k++;
        end
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (valid !== 1'b0 || pop !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_state: valid=%b pop=%b required 0/0000", valid, pop);
        end
        rst_n = 1'b1;
        clear_logs();
        push(2, 16'hE200);
        push(0, 16'hE000);
        run_until(2, 30, "midreset");
        if (log_ch.size() >= 2 && pop_chn.size() >= 1) begin
            total++;
            if (pop_chn[0] != 0 || log_ch[0] !== 2'd0 || log_data[0] !== 16'hE000) begin
                bad++;
                $display("FAIL midreset_first: popch=%0d ch=%0d data=%h required 0/0/E000",
                         pop_chn[0], log_ch[0], log_data[0]);
            end
            total++;
            if (log_ch[1] !== 2'd2 || log_data[1] !== 16'hE200) begin
                bad++;
                $display("FAIL midreset_second: ch=%0d data=%h required 2/E200", log_ch[1], log_data[1]);
            end
        end
    endtask

    task automatic test_random_mix();
        logic [DW-1:0] exp_q [NUM_CH][$];
        logic [DW-1:0] e;
        int pushed, seen, order_err, left, k;
        pushed = 0;
        seen = 0;
        order_err = 0;
        do_reset();
        for (int c = 0; c < 10000 + 600; c++) begin
            if (c < 10000) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if ($urandom_range(0, 7) == 0 && q[ch].size() < 8) begin
                        e = DW'(ch * 4096) | DW'(pushed % 4096);
                        push(ch, e);
                        exp_q[ch].push_back(e);
                        pushed++;
                    end
                end
                ready = ($urandom_range(0, 3) != 0);
            end else begin
                ready = 1'b1;
            end
            step();
            while (log_ch.size() > 0) begin
                k = int'(log_ch.pop_front());
                e = log_data.pop_front();
                seen++;
                if (exp_q[k].size() == 0) order_err++;
                else if (exp_q[k].pop_front() !== e) order_err++;
            end
        end
        left = 0;
        for (int ch = 0; ch < NUM_CH; ch++) left += exp_q[ch].size();
        total++;
        if (order_err != 0) begin
            bad++;
            $display("FAIL random_order: errors=%0d required 0", order_err);
        end
        total++;
        if (left != 0 || seen != pushed) begin
            bad++;
            $display("FAIL random_drain: left=%0d seen=%0d pushed=%0d required 0/%0d", left, seen, pushed, pushed);
        end
        total++;
        if (pop_err != 0) begin
            bad++;
            $display("FAIL pop_on_empty: count=%0d required 0", pop_err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) dout[i] = '0;
        refresh();
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_round_robin();
        test_burst_limit();
        test_backpressure();
        test_reset_mid();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rr_drain.md
# fifo_rr_drain

Round-robin drain stage downstream of a bank of NUM_CH `fifo` instances; it replaces the bare output mux. It watches each FIFO's empty flag and issues single-cycle pops. It accounts for the FIFO's one-cycle registered read latency, then presents each word on a valid/ready output with its source channel ID. The per-grant burst limit bounds how long one channel can hold the output.

## Interface
- NUM_CH, 4, number of upstream FIFOs (≥2)
- DATA_WIDTH, 16, word width; equals the FIFO_WIDTH of the upstream FIFOs
- CH_BITS, 2, channel-ID width; must satisfy 2^CH_BITS ≥ NUM_CH
- MAX_BURST, 4, maximum words drained per grant (≥1)
- Clock and reset: clk in the decided interface; rst_n is synchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  reset
- i_empty  in  NUM_CH  per-channel FIFO empty flag; bit i is channel i
- i_data  in  NUM_CH*DATA_WIDTH  per-channel FIFO outputs, flattened; channel i is at [i*DATA_WIDTH +: DATA_WIDTH]
- o_pop  out  NUM_CH  one-hot pop strobes to the FIFOs
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accept
- o_data  out  DATA_WIDTH  output word
- o_ch  out  CH_BITS  source channel of o_data

## Operation
- FSM states: ARB, POP, CAP, OUT.
- ARB
  - If any i_empty bit is 0, grant the first non-empty channel, searching from (last_grant+1) mod NUM_CH upward with wrap.
  - Clear burst_cnt and go to POP.
  - If all channels are empty, stay in ARB.
- POP: drive o_pop[grant]=1 for exactly this cycle, then go to CAP.
- CAP: load o_data from i_data[grant], load o_ch from grant, set o_valid=1, then go to OUT.
- OUT
  - Hold o_data, o_ch and o_valid while i_ready=0.
  - On handshake (o_valid & i_ready), increment burst_cnt.
  - After the handshake, if burst_cnt+1 < MAX_BURST and i_empty[grant]=0: clear o_valid and go to POP on the same channel.
  - Otherwise: clear o_valid, set last_grant=grant, and go to ARB.
- o_pop is decoded from state POP and is forced to 0 while rst_n=0. No more than one o_pop bit is ever high.
- i_data and i_empty are only sampled in CAP, OUT and ARB. By those states the FIFO flags already reflect the previous pop.
- The block never pops an empty FIFO, because i_empty is checked in the state immediately before every POP.
- burst_cnt is $clog2(MAX_BURST+1) bits wide, saturates at MAX_BURST, and is cleared in ARB.

## Timing
- Reset values: state=ARB, last_grant=NUM_CH-1 (so channel 0 wins first), burst_cnt=0, o_valid=0, o_data=0, o_ch=0, o_pop=0.
- Latency: a FIFO going non-empty at cycle T produces o_pop at T+1 and o_valid at T+3.
- Sustained rate is one word per 3 cycles with i_ready held at 1. Within a burst, OUT handshake → POP → CAP → OUT.
- Backpressure: while i_ready=0, o_data and o_ch are held stable and no pop is issued.
- i_ready is ignored while o_valid=0.
- Reset mid-operation
  - The FSM returns to ARB on the next edge and any in-flight word is dropped.
  - The upstream FIFOs share rst_n, so no data is orphaned.
- If a channel drains during a burst, the burst ends early and arbitration resumes from that channel +1.
- Wrap-around: after a grant on channel NUM_CH-1, channel 0 has the highest priority.

## Structure
- Package fifo_drain_pkg holds:
  - the state enum typedef (ARB, POP, CAP, OUT)
  - default parameter constants
  - a function computing burst_cnt width
- Sub-module rr_pick (combinational, parameterised on NUM_CH and CH_BITS)
  - Inputs: request vector and last_grant.
  - Outputs: grant index and any_req.
  - It is the only natural split; the FSM and datapath stay in fifo_rr_drain.

## Test plan
- Single channel: reset, then channel 2 holds 3 words (0xA001, 0xA002, 0xA003) with i_ready=1.
  - Three outputs with o_ch=2, in order.
  - Exactly 3 o_pop[2] pulses, spaced 3 cycles apart.
  - Returns to ARB.
- Round robin: all 4 channels hold 1 word each, MAX_BURST=4.
  - Output o_ch sequence is 0,1,2,3.
  - A second fill of the same channels yields 0,1,2,3 again.
- Burst limit: channel 0 holds 6 words and channel 1 holds 2.
  - Output o_ch sequence is 0,0,0,0,1,1,0,0.
- Backpressure: i_ready=0 for 10 cycles while o_valid=1 with o_data=0x5555.
  - o_data and o_ch stable throughout, no o_pop, one handshake on release.
- Reset mid-burst: assert rst_n=0 in the CAP state.
  - Next cycle: o_valid=0 and o_pop=0.
  - After release, the first grant goes to channel 0 if it is non-empty.
- Never-pop-empty: a random fill/drain mix over 10k cycles checked by a scoreboard.
  - No o_pop[i] while i_empty[i]=1.
  - Per-channel word order is preserved.
